// File: rtl/counter_chain_feeder.sv
// -----------------------------------------------------------------------------
// counter_chain_feeder
//
// Streaming front end for the LOOKAHEAD8 counter chain. Operand frames arrive
// one beat per accepted in_valid/in_ready transfer and are presented to the
// compressor tree as one wide parallel word behind an out_valid/out_ready
// handshake.
//
// Beat layout by slot (slot counter runs 0..5, advances per accepted beat):
//   slot 0   : in_data[2:0] -> C0, [4:3] -> C1, [6:5] -> C2 (upper bits ignored)
//   slot 1..5: in_data -> CL_00, CL_01, CL_02, CL_03, CL_10
// A frame completes on the slot-5 beat or on any beat carrying in_last. Slots
// not written before completion stay zero; out_partial flags an early finish.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_data/in_valid/
//   in_last/in_ready     beat stream (in_ready is a flop output)
//   out_c0/out_c1/out_c2 frame carry-in columns
//   out_cl00..out_cl10   frame column vectors, LENGTH bits each (LENGTH >= 7)
//   out_partial          frame was closed early by in_last
//   out_valid/out_ready  frame handshake (out_valid is a flop output)
//
// Build option
//   COUNTER_FEED_PINGPONG_EN : when defined, the fill buffer keeps collecting
//   while the output register holds a frame, so a second frame can be staged
//   (one collecting, one holding). in_ready drops only when both are occupied.
//   When undefined, in_ready = !out_valid: collection pauses while a frame is
//   held and resumes the cycle after the output handshake.
// -----------------------------------------------------------------------------
module counter_chain_feeder #(
    parameter int LENGTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LENGTH-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [2:0]        out_c0,
    output logic [1:0]        out_c1,
    output logic [1:0]        out_c2,
    output logic [LENGTH-1:0] out_cl00,
    output logic [LENGTH-1:0] out_cl01,
    output logic [LENGTH-1:0] out_cl02,
    output logic [LENGTH-1:0] out_cl03,
    output logic [LENGTH-1:0] out_cl10,
    output logic              out_partial,
    output logic              out_valid,
    input  logic              out_ready
);

    // One complete operand frame. cl[0..4] = CL_00, CL_01, CL_02, CL_03, CL_10.
    typedef struct packed {
        logic                   partial;
        logic [4:0][LENGTH-1:0] cl;
        logic [1:0]             c2;
        logic [1:0]             c1;
        logic [2:0]             c0;
    } frame_t;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } fill_state_e;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } out_state_e;

    localparam logic [2:0] LAST_SLOT = 3'd5;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    frame_t      fill_q,       fill_d;
    logic [2:0]  slot_q,       slot_d;
    fill_state_e fill_state_q, fill_state_d;
    frame_t      out_q,        out_d;
    out_state_e  out_state_q,  out_state_d;
    logic        in_ready_q,   in_ready_d;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    logic   accept;
    logic   at_last_slot;
    logic   complete;
    logic   out_free;
    frame_t merged;

    always_comb begin
        fill_d       = fill_q;
        slot_d       = slot_q;
        fill_state_d = fill_state_q;
        out_d        = out_q;
        out_state_d  = out_state_q;

        accept       = in_valid && in_ready_q;
        at_last_slot = (slot_q == LAST_SLOT);
        complete     = accept && (at_last_slot || in_last);
        // The output register can take a frame this edge if it is empty or
        // its current frame is being consumed right now.
        out_free     = (out_state_q == EMPTY) || out_ready;

        // Fill buffer with the current beat merged into its slot.
        merged = fill_q;
        if (accept) begin
            case (slot_q)
                3'd0: begin
                    merged.c0 = in_data[2:0];
                    merged.c1 = in_data[4:3];
                    merged.c2 = in_data[6:5];
                end
                3'd1:    merged.cl[0] = in_data;
                3'd2:    merged.cl[1] = in_data;
                3'd3:    merged.cl[2] = in_data;
                3'd4:    merged.cl[3] = in_data;
                3'd5:    merged.cl[4] = in_data;
                default: ;
            endcase
        end
        merged.partial = complete && !at_last_slot;

        if (accept) begin
            slot_d = complete ? 3'd0 : slot_q + 3'd1;
            fill_d = merged;
        end

        if (fill_state_q == FULL) begin
            // A staged frame moves up as soon as the held one is taken, so
            // out_valid stays high across the swap.
            if (out_free) begin
                out_d        = fill_q;
                out_state_d  = HOLD;
                fill_d       = '0;
                fill_state_d = COLLECT;
            end
        end else if (complete) begin
            if (out_free) begin
                // Completion and output handshake in one cycle: the new
                // frame simply overwrites the one being consumed.
                out_d       = merged;
                out_state_d = HOLD;
                fill_d      = '0;
            end else begin
                fill_d       = merged;
                fill_state_d = FULL;
            end
        end else if ((out_state_q == HOLD) && out_ready) begin
            out_state_d = EMPTY;
        end

        // in_ready is computed from next state and registered so that it has
        // no combinational dependence on out_ready, and so it stays low for
        // the first cycle after reset release.
`ifdef COUNTER_FEED_PINGPONG_EN
        in_ready_d = (fill_state_d == COLLECT);
`else
        in_ready_d = (out_state_d == EMPTY);
`endif
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q       <= '0;
            slot_q       <= 3'd0;
            fill_state_q <= COLLECT;
            out_q        <= '0;
            out_state_q  <= EMPTY;
            in_ready_q   <= 1'b0;
        end else begin
            fill_q       <= fill_d;
            slot_q       <= slot_d;
            fill_state_q <= fill_state_d;
            out_q        <= out_d;
            out_state_q  <= out_state_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready    = in_ready_q;
    assign out_valid   = (out_state_q == HOLD);
    assign out_partial = out_q.partial;
    assign out_c0      = out_q.c0;
    assign out_c1      = out_q.c1;
    assign out_c2      = out_q.c2;
    assign out_cl00    = out_q.cl[0];
    assign out_cl01    = out_q.cl[1];
    assign out_cl02    = out_q.cl[2];
    assign out_cl03    = out_q.cl[3];
    assign out_cl10    = out_q.cl[4];

endmodule
